// File: rtl/fft_pingpong_reorder.sv
// Double-buffered frame reorder buffer. Writes land in one bank at arbitrary addresses
// while the previous frame streams out of the other bank in linear or bit-reversed order.
module fft_pingpong_reorder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clock_c,
    input  logic              reset,
    input  logic              ce,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_en,
    input  logic              swap,
    input  logic              rd_bitrev,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              overrun
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    // Both banks share one array; the bank bit is the MSB of the index.
    logic [DATA_W-1:0] mem_q [2*DEPTH];

    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_active_q, rd_active_d;
    logic              mode_q, mode_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [ADDR_W-1:0] rd_cnt_rev;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_fire;

    always_comb begin
        rd_cnt_rev = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            rd_cnt_rev[i] = rd_cnt_q[ADDR_W-1-i];
        end
    end

    assign rd_addr = mode_q ? rd_cnt_rev : rd_cnt_q;
    assign rd_fire = ce && rd_active_q && !swap;

    // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_cnt_d    = rd_cnt_q;
        rd_active_d = rd_active_q;
        mode_d      = mode_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        overrun_d   = overrun_q;

        if (ce) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            if (swap) begin
                // A swap always wins; an unfinished readout is abandoned and flagged.
                wr_bank_d   = ~wr_bank_q;
                rd_cnt_d    = '0;
                rd_active_d = 1'b1;
                mode_d      = rd_bitrev;
                if (rd_active_q) begin
                    overrun_d = 1'b1;
                end
            end else if (rd_active_q) begin
                rd_valid_d = 1'b1;
                rd_last_d  = (rd_cnt_q == LAST_IDX);
                rd_cnt_d   = rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    rd_active_d = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_c) begin
        if (reset) begin
            wr_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            rd_active_q <= 1'b0;
            mode_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            overrun_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_active_q <= rd_active_d;
            mode_q      <= mode_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            overrun_q   <= overrun_d;
            if (rd_fire) begin
                rd_data_q <= mem_q[{~wr_bank_q, rd_addr}];
            end
        end
    end

    // NOTE: the sample memory has no reset so it maps onto plain RAM; stale contents are harmless.
    always_ff @(posedge clock_c) begin
        if (!reset && ce && wr_en) begin
            mem_q[{wr_bank_q, wr_addr}] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign overrun  = overrun_q;

endmodule
